// File: rtl/serial_max_pkg.sv
// -----------------------------------------------------------------------------
// serial_max_pkg
// Shared types and helpers for the bit-serial signed-maximum receiver.
//   state_t            : FSM state encoding (IDLE, SHIFT, DONE)
//   N_DEFAULT          : default operand width
//   sign_first_winner  : per-beat ordering decision for MSB-first signed data
// -----------------------------------------------------------------------------
package serial_max_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_DEFAULT = 3;

    // Returns 1 when operand a is the larger one, assuming a_bit != b_bit.
    // On the sign beat a 0 means non-negative, so the 0 side wins; on every
    // later beat the usual unsigned rule applies and the 1 side wins.
    function automatic logic sign_first_winner(
        input logic a_bit,
        input logic b_bit,
        input logic first
    );
        logic a_wins;
        a_wins = first ? ~a_bit : a_bit;
        // b_bit only matters through the caller's a_bit != b_bit guard.
        return a_wins | (b_bit & 1'b0);
    endfunction

endpackage : serial_max_pkg

// File: rtl/serial_signed_max_sipo_shift.sv
// -----------------------------------------------------------------------------
// sipo_shift
// Serial-in parallel-out shift register, LSB-side insert, so a stream sent
// MSB first ends up in natural bit order after N enabled cycles.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (takes priority over en)
//   en     : shift d in this cycle
//   d      : serial data bit
//   q      : parallel contents
// -----------------------------------------------------------------------------
module sipo_shift #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= {r_q[N-2:0], d};
        end
    end

    assign q = r_q;

endmodule : sipo_shift

// File: rtl/serial_signed_max.sv
// -----------------------------------------------------------------------------
// serial_signed_max
// Receives two N-bit two's-complement operands bit-serially (MSB first),
// resolves their ordering as the bits arrive, and presents the larger one as
// a parallel word with a one-cycle strobe.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : begin a transfer (accepted only in IDLE, not in the o_vld cycle)
//   a_bit   : serial bit of operand a, MSB first
//   b_bit   : serial bit of operand b, MSB first
//   bit_vld : a_bit/b_bit valid this cycle
//   busy    : high from accepted start until o_vld
//   o       : signed max(a, b), held until the next o_vld
//   o_vld   : one-cycle strobe, o and a_gt_b updated this cycle
//   a_gt_b  : a > b strictly, held with o
// -----------------------------------------------------------------------------
module serial_signed_max
    import serial_max_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         a_bit,
    input  logic         b_bit,
    input  logic         bit_vld,
    output logic         busy,
    output logic [N-1:0] o,
    output logic         o_vld,
    output logic         a_gt_b
);

    localparam int CW = $clog2(N + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_decided;
    logic          r_a_wins;
    logic [N-1:0]  r_o;
    logic          r_o_vld;
    logic          r_busy;
    logic          r_a_gt_b;

    logic [N-1:0]  w_sa;
    logic [N-1:0]  w_sb;
    logic [N-1:0]  w_winner;
    logic          w_start_ok;
    logic          w_shift_en;
    logic          w_last_beat;

    // The strobe cycle is already IDLE in state terms, but a start there is
    // still ignored so the next transfer always begins after o_vld.
    assign w_start_ok  = (r_state == IDLE) && start && !r_o_vld;
    assign w_shift_en  = (r_state == SHIFT) && bit_vld;
    assign w_last_beat = w_shift_en && (r_cnt == CW'(N - 1));

    // Undecided means all bits matched, and a is returned for a tie.
    assign w_winner = (r_decided && !r_a_wins) ? w_sb : w_sa;

    sipo_shift #(.N(N)) u_sipo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_ok),
        .en    (w_shift_en),
        .d     (a_bit),
        .q     (w_sa)
    );

    sipo_shift #(.N(N)) u_sipo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_ok),
        .en    (w_shift_en),
        .d     (b_bit),
        .q     (w_sb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next-state value is assigned a default before the case so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last_beat) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Beat counter and running decision. Only the first differing beat
    // updates the winner; later beats cannot overturn it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_a_wins  <= 1'b0;
        end else if (w_start_ok) begin
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_a_wins  <= 1'b0;
        end else if (w_shift_en) begin
            r_cnt <= r_cnt + CW'(1);
            if (!r_decided && (a_bit != b_bit)) begin
                r_decided <= 1'b1;
                r_a_wins  <= sign_first_winner(a_bit, b_bit, r_cnt == '0);
            end
        end
    end

    // Result registers are loaded on the edge leaving DONE, so o_vld lands
    // one cycle after the edge that accepts the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o      <= '0;
            r_o_vld  <= 1'b0;
            r_busy   <= 1'b0;
            r_a_gt_b <= 1'b0;
        end else begin
            r_o_vld <= (r_state == DONE);
            if (w_start_ok) begin
                r_busy <= 1'b1;
            end else if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
            if (r_state == DONE) begin
                r_o      <= w_winner;
                r_a_gt_b <= r_decided & r_a_wins;
            end
        end
    end

    assign o      = r_o;
    assign o_vld  = r_o_vld;
    assign busy   = r_busy;
    assign a_gt_b = r_a_gt_b;

endmodule : serial_signed_max
